// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage RAM port arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [1:0] {NONE, IF, MLO, MHI} tag_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Memory-stage access sequencer: state, request fields latched at acceptance,
// and the in-flight tag that steers next cycle's RAM read data.
//
// state | meaning
// IDLE  | no memory access; mem_req may be accepted, fetch may issue
// LO    | first (or only) word of the accepted access issues
// HI    | second word of a wide access issues at addr+1
// DONE  | mem_done pulses; a new mem_req may be accepted, fetch may issue
module mem_arb_fsm
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_wide,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              hold_off,
  input  logic              fetch_go,
  output logic              slot_free,
  output logic              accept,
  output logic              issue_lo,
  output logic              issue_hi,
  output logic              done,
  output logic              lat_we,
  output logic              lat_wide,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [31:0]       lat_wdata,
  output tag_t              tag
);

  state_t state, state_nxt;
  tag_t   tag_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tag       <= NONE;
      lat_we    <= 1'b0;
      lat_wide  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      tag   <= tag_nxt;
      if (accept) begin
        lat_we    <= mem_we;
        lat_wide  <= mem_wide;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? LO : IDLE;
      LO:      state_nxt = lat_wide ? HI : DONE;
      HI:      state_nxt = DONE;
      DONE:    state_nxt = accept ? LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_free = (state == IDLE) || (state == DONE);
    accept    = slot_free && mem_req && !hold_off && !rst;
    issue_lo  = (state == LO) && !rst;
    issue_hi  = (state == HI) && !rst;
    done      = (state == DONE) && !rst;
    tag_nxt   = NONE;
    if (issue_hi)      tag_nxt = MHI;
    else if (issue_lo) tag_nxt = MLO;
    else if (fetch_go) tag_nxt = IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the memory stage.
// Define FETCH_STARVE_GUARD_EN to let a starved fetch beat a new mem_req.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              stall_if,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_wide,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);

  logic              slot_free, accept, issue_lo, issue_hi, done;
  logic              lat_we, lat_wide;
  logic [ADDR_W-1:0] lat_addr, hi_addr, addr_q;
  logic [31:0]       lat_wdata, rdata_q;
  logic [WORD_W-1:0] hi_q;
  logic              fetch_go, guard_win, if_drop_q;
  tag_t              tag;
  logic              unused_hi_bits;

  mem_arb_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wide  (mem_wide),
    .mem_addr  (mem_addr[ADDR_W-1:0]),
    .mem_wdata (mem_wdata),
    .hold_off  (guard_win),
    .fetch_go  (fetch_go),
    .slot_free (slot_free),
    .accept    (accept),
    .issue_lo  (issue_lo),
    .issue_hi  (issue_hi),
    .done      (done),
    .lat_we    (lat_we),
    .lat_wide  (lat_wide),
    .lat_addr  (lat_addr),
    .lat_wdata (lat_wdata),
    .tag       (tag)
  );

  // The RAM only sees ADDR_W bits, so the +1 wrap happens at that width.
  assign unused_hi_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
  assign hi_addr        = lat_addr + ADDR_W'(1);

  assign fetch_go = if_req && slot_free && !accept && !rst;
  assign stall_if = if_req && !fetch_go && !rst;
  assign mem_done = done;
  assign if_valid = (tag == IF) && !if_drop_q && !if_flush && !rst;
  assign if_rdata = if_valid ? ram_rdata : '0;

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (issue_lo) begin
      ram_addr = lat_addr;
      ram_we   = lat_we;
      if (lat_we) ram_wdata = lat_wide ? lat_wdata[31:16] : lat_wdata[15:0];
    end else if (issue_hi) begin
      ram_addr = hi_addr;
      ram_we   = lat_we;
      if (lat_we) ram_wdata = lat_wdata[15:0];
    end else if (fetch_go) begin
      ram_addr = if_addr[ADDR_W-1:0];
    end
  end

  // The final word arrives in the DONE cycle, so it is passed straight
  // through alongside mem_done and captured for holding afterwards.
  always_comb begin
    mem_rdata = rdata_q;
    if (done && !lat_we)
      mem_rdata = lat_wide ? {hi_q, ram_rdata} : {16'h0000, ram_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rdata_q   <= '0;
      hi_q      <= '0;
      if_drop_q <= 1'b0;
    end else begin
      addr_q    <= ram_addr;
      if_drop_q <= if_flush;
      if (tag == MLO && lat_wide) hi_q <= ram_rdata;
      if (done) rdata_q <= mem_rdata;
    end
  end

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign guard_win = if_req && slot_free && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst || !if_req || fetch_go)
      starve_cnt <= '0;
    else if (stall_if && starve_cnt != CNT_W'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end
`else
  assign guard_win = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal scenarios plus random traffic
// checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 20;
  localparam int STARVE_LIMIT = 4;
`ifdef FETCH_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  bit          clk;
  logic        rst;
  logic        if_req, if_flush, stall_if, if_valid;
  logic [31:0] if_addr;
  logic [15:0] if_rdata;
  logic        mem_req, mem_we, mem_wide, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [19:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .stall_if(stall_if), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wide(mem_wide),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT, and the model's own shadow copy
  logic [15:0] ram_d [bit [19:0]];
  logic [15:0] ram_m [bit [19:0]];

  function automatic logic [15:0] init_val(bit [19:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[19:16], 12'h000};
  endfunction

  function automatic logic [15:0] rd_m(bit [19:0] a);
    return ram_m.exists(a) ? ram_m[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ram_d.exists(ram_addr) ? ram_d[ram_addr] : init_val(ram_addr);
    if (ram_we) ram_d[ram_addr] = ram_wdata;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted access issues word k at acceptance+1+k and completes
  // one cycle after its last word; the slot is free with no job or on completion.
  bit          job;
  int          acc_c, cyc, starve;
  bit          j_we, j_wide;
  logic [19:0] j_addr, last_addr;
  logic [31:0] j_wdata, hold;
  logic [15:0] rd0, rd1, f_data;
  bit          f_pend;

  always @(negedge clk) begin
    int len, k;
    bit done_now, free, guard, acc, fi, mi, e_we, e_stall, e_valid;
    logic [19:0] e_addr, ia;
    logic [15:0] e_wd, e_ifd;
    logic [31:0] e_rd;
    if (rst) begin
      job = 0; hold = 0; last_addr = 0; f_pend = 0; starve = 0;
    end else begin
      len      = j_wide ? 2 : 1;
      done_now = job && (cyc == acc_c + len + 1);
      free     = !job || done_now;
      guard    = GUARD && (starve == STARVE_LIMIT) && if_req && free;
      acc      = free && mem_req && !guard;
      fi       = free && if_req && !acc;
      k        = cyc - acc_c - 1;
      mi       = job && !done_now && k >= 0 && k < len;
      e_we = 0; e_wd = 0; e_addr = last_addr; ia = 0;
      if (mi) begin
        ia     = j_addr + 20'(k);
        e_addr = ia;
        e_we   = j_we;
        if (j_we) e_wd = (j_wide && k == 0) ? j_wdata[31:16] : j_wdata[15:0];
      end else if (fi) begin
        e_addr = if_addr[19:0];
      end
      e_stall = if_req && !fi;
      e_valid = f_pend && !if_flush;
      e_ifd   = e_valid ? f_data : 16'h0;
      e_rd    = hold;
      if (done_now && !j_we) e_rd = j_wide ? {rd0, rd1} : {16'h0, rd0};

      chk("m_stall_if", stall_if, e_stall);
      chk("m_if_valid", if_valid, e_valid);
      chk("m_if_rdata", if_rdata, e_ifd);
      chk("m_mem_done", mem_done, done_now);
      chk("m_mem_rdata", mem_rdata, e_rd);
      chk("m_ram_addr", ram_addr, e_addr);
      chk("m_ram_we", ram_we, e_we);
      chk("m_ram_wdata", ram_wdata, e_wd);

      hold = e_rd;
      if (mi) begin
        if (j_we) ram_m[ia] = e_wd;
        else if (k == 0) rd0 = rd_m(ia);
        else rd1 = rd_m(ia);
      end
      f_pend = fi && !if_flush;
      if (fi) f_data = rd_m(if_addr[19:0]);
      last_addr = e_addr;
      if (done_now) job = 0;
      if (acc) begin
        job = 1; acc_c = cyc; j_we = mem_we; j_wide = mem_wide;
        j_addr = mem_addr[19:0]; j_wdata = mem_wdata;
      end
      if (!if_req || fi) starve = 0;
      else if (e_stall && starve < STARVE_LIMIT) starve++;
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; mem_wide = 0;
  endtask

  initial begin
    rst = 1; idle_in(); if_addr = 0; mem_addr = 0; mem_wdata = 0;
    ram_d[20'h00100] = 16'hA1B2; ram_m[20'h00100] = 16'hA1B2;
    ram_d[20'h00101] = 16'hC3D4; ram_m[20'h00101] = 16'hC3D4;
    ram_d[20'h00020] = 16'h1234; ram_m[20'h00020] = 16'h1234;
    nxt(); nxt(); rst = 0;
    @(negedge clk);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_flags", {stall_if, if_valid, mem_done, ram_we}, 0);
    nxt();

    // fetch only
    if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("fo_stall0", stall_if, 0); nxt();
    if_addr = 32'h101;
    @(negedge clk); chk("fo_valid0", if_valid, 1); chk("fo_data0", if_rdata, 16'hA1B2);
    chk("fo_stall1", stall_if, 0); nxt();
    if_req = 0;
    @(negedge clk); chk("fo_valid1", if_valid, 1); chk("fo_data1", if_rdata, 16'hC3D4); nxt();

    // narrow load against a fetch
    mem_req = 1; mem_we = 0; mem_wide = 0; mem_addr = 32'h20; if_req = 1; if_addr = 32'h102;
    @(negedge clk); chk("nl_stall_acc", stall_if, 1); nxt();
    @(negedge clk); chk("nl_stall_lo", stall_if, 1); chk("nl_addr", ram_addr, 20'h20); nxt();
    mem_req = 0;
    @(negedge clk); chk("nl_done", mem_done, 1); chk("nl_rdata", mem_rdata, 32'h0000_1234);
    chk("nl_fetch", stall_if, 0); chk("nl_faddr", ram_addr, 20'h102); nxt();
    if_req = 0; nxt();

    // wide push wrapping the word address
    mem_req = 1; mem_we = 1; mem_wide = 1; mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("wp_done_acc", mem_done, 0); nxt();
    @(negedge clk); chk("wp_we0", ram_we, 1); chk("wp_addr0", ram_addr, 20'hFFFFF);
    chk("wp_wd0", ram_wdata, 16'hDEAD); nxt();
    @(negedge clk); chk("wp_we1", ram_we, 1); chk("wp_addr1", ram_addr, 0);
    chk("wp_wd1", ram_wdata, 16'hBEEF); nxt();
    mem_req = 0;
    @(negedge clk); chk("wp_done", mem_done, 1); nxt();

    // wide pop, then a held mem_req accepted in DONE
    mem_req = 1; mem_we = 0; mem_wide = 1; mem_addr = 32'hFFFF_FFFF;
    nxt(); nxt(); nxt();
    mem_addr = 32'h20; mem_wide = 0;
    @(negedge clk); chk("pop_done", mem_done, 1); chk("pop_rdata", mem_rdata, 32'hDEAD_BEEF); nxt();
    mem_req = 0;
    @(negedge clk); chk("b2b_lo_done", mem_done, 0); chk("b2b_addr", ram_addr, 20'h20); nxt();
    @(negedge clk); chk("b2b_done", mem_done, 1); chk("b2b_rdata", mem_rdata, 32'h0000_1234); nxt();

    // flush after a fetch issue
    if_req = 1; if_addr = 32'h100; nxt();
    if_req = 0; if_flush = 1;
    @(negedge clk); chk("fl_valid", if_valid, 0); nxt();
    if_flush = 0;

    // reset in HI
    mem_req = 1; mem_we = 0; mem_wide = 1; mem_addr = 32'h100; nxt(); nxt();
    rst = 1; mem_req = 0; nxt(); rst = 0;
    @(negedge clk); chk("rh_done", mem_done, 0); chk("rh_rdata", mem_rdata, 0);
    chk("rh_addr", ram_addr, 0); chk("rh_flags", {stall_if, if_valid, ram_we, ram_wdata}, 0); nxt();

    // starvation: back-to-back narrow loads with fetch waiting
    mem_req = 1; mem_we = 0; mem_wide = 0; mem_addr = 32'h20; if_req = 1; if_addr = 32'h100;
    repeat (4) nxt();
    @(negedge clk);
    chk("sg_done", mem_done, 1);
`ifdef FETCH_STARVE_GUARD_EN
    chk("sg_stall", stall_if, 0); chk("sg_addr", ram_addr, 20'h100);
`else
    chk("sg_stall", stall_if, 1);
`endif
    nxt();
    idle_in(); nxt(); nxt(); nxt();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if_req   = ($urandom_range(0, 2) != 0);
      if_addr  = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 31));
      if_flush = ($urandom_range(0, 9) == 0);
      mem_req  = $urandom_range(0, 1);
      mem_we   = $urandom_range(0, 1);
      mem_wide = $urandom_range(0, 1);
      mem_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF
               : (($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 31)));
      mem_wdata = $urandom;
      nxt();
    end
    rst = 0; idle_in(); nxt(); nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
